ahb_sensor_in: RTL and testbench

AHB-Lite slave that carries data from the rider to the CPU. It is the input-direction counterpart of the display output slave. It synchronises and debounces the active-low push buttons and the wheel and crank reed switches. It exposes debounced levels, sticky press/revolution event flags and wrapping revolution counters as four read words, and drives IRQ while any event flag is set.

---
 rtl/ahb_sensor_pkg.sv | 28 ++
 rtl/sensor_debounce.sv | 53 +++++
 rtl/ahb_sensor_in.sv | 135 +++++++++++++
 tb/tb_ahb_sensor_in.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sensor_pkg.sv
// ahb_sensor_pkg
// Shared constants for the rider-input AHB-Lite slave:
//   - word offsets of the four registers (HADDR[3:2])
//   - bit positions of the wheel/crank fields in STATUS and EVENTS
//   - the idle HTRANS encoding
//   - the registered data-phase descriptor captured from the address phase
package ahb_sensor_pkg;

  localparam logic [1:0] STATUS      = 2'd0;
  localparam logic [1:0] EVENTS      = 2'd1;
  localparam logic [1:0] WHEEL_COUNT = 2'd2;
  localparam logic [1:0] CRANK_COUNT = 2'd3;

  localparam int WHEEL_BIT      = 8;
  localparam int CRANK_BIT      = 9;
  localparam int WHEEL_WRAP_BIT = 10;
  localparam int CRANK_WRAP_BIT = 11;

  localparam logic [1:0] NO_TRANSFER = 2'b00;

  // What the pending data phase has to do, captured at the end of the address phase.
  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [1:0] addr;
  } dphase_t;

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce
// Two-flop synchroniser followed by a counting debouncer for one
// asynchronous active-high input.
// Ports:
//   HCLK   - clock
//   HRESET - synchronous active-high reset
//   din    - asynchronous active-high input
//   level  - debounced level
//   rise   - one-cycle pulse, high in the cycle whose closing edge takes level 0->1
module sensor_debounce #(
  parameter int CYCLES = 5000
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic din,
  output logic level,
  output logic rise
);

  // cnt only has to reach CYCLES-1.
  localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          sample;
  logic          fire;

  assign sample = sync[1];
  // The CYCLES-th consecutive differing sample flips the level.
  assign fire   = (sample != level) && (cnt == LAST);
  // Combinational so the caller's flags and counters move on the same edge as level.
  assign rise   = fire & sample;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      if (sample == level) begin
        cnt <= '0;
      end else if (fire) begin
        level <= sample;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_sensor_in.sv
// ahb_sensor_in
// AHB-Lite slave presenting rider inputs (push buttons, wheel and crank reed
// switches) to the CPU as four read words: STATUS, EVENTS (W1C),
// WHEEL_COUNT and CRANK_COUNT (write clears).
// Ports:
//   HCLK, HRESET            - clock, synchronous active-high reset
//   HADDR/HWDATA/HSIZE/
//   HTRANS/HWRITE/HREADY/HSEL - AHB-Lite slave request (only HADDR[3:2] decoded)
//   HRDATA, HREADYOUT       - read data, always-ready response
//   nButton, nWheel, nCrank - asynchronous active-low rider inputs
//   IRQ                     - high while any EVENTS bit is set
module ahb_sensor_in
  import ahb_sensor_pkg::*;
#(
  parameter int NUM_BUTTONS         = 2,
  parameter int BTN_DEBOUNCE_CYCLES = 50000,
  parameter int SNS_DEBOUNCE_CYCLES = 5000,
  parameter int COUNT_WIDTH         = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [31:0]            HADDR,
  input  logic [31:0]            HWDATA,
  input  logic [2:0]             HSIZE,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic                   HREADY,
  input  logic                   HSEL,
  output logic [31:0]            HRDATA,
  output logic                   HREADYOUT,
  input  logic [NUM_BUTTONS-1:0] nButton,
  input  logic                   nWheel,
  input  logic                   nCrank,
  output logic                   IRQ
);

  localparam int NIN = NUM_BUTTONS + 2;
  localparam int WI  = NUM_BUTTONS;      // wheel index in lvl/rise
  localparam int CI  = NUM_BUTTONS + 1;  // crank index

  // ---------------- input conditioning ----------------
  logic [NIN-1:0] pin_act, lvl, rise;

  assign pin_act = ~{nCrank, nWheel, nButton};

  for (genvar gi = 0; gi < NIN; gi++) begin : g_in
    sensor_debounce #(
      .CYCLES(gi < NUM_BUTTONS ? BTN_DEBOUNCE_CYCLES : SNS_DEBOUNCE_CYCLES)
    ) u_db (
      .HCLK  (HCLK),
      .HRESET(HRESET),
      .din   (pin_act[gi]),
      .level (lvl[gi]),
      .rise  (rise[gi])
    );
  end

  // ---------------- bus pipeline ----------------
  dphase_t dp;
  logic    ap_valid, wr_commit;

  assign ap_valid  = HREADY & HSEL & (HTRANS != NO_TRANSFER);
  assign wr_commit = dp.wr & HREADY;
  assign HREADYOUT = 1'b1;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp <= '0;
    end else if (HREADY) begin
      dp.wr   <= ap_valid & HWRITE;
      dp.rd   <= ap_valid & ~HWRITE;
      dp.addr <= HADDR[3:2];
    end
  end

  // ---------------- counters and events ----------------
  // Index 0 = wheel, 1 = crank.
  logic [1:0][COUNT_WIDTH-1:0] rev_cnt;
  logic [1:0]                  sns_rise, cnt_clr, wrap;
  logic [11:0]                 ev_q, ev_set, ev_w1c;

  assign sns_rise = {rise[CI], rise[WI]};
  assign cnt_clr  = {wr_commit && dp.addr == CRANK_COUNT,
                     wr_commit && dp.addr == WHEEL_COUNT};
  assign ev_w1c   = (wr_commit && dp.addr == EVENTS) ? HWDATA[11:0] : 12'h0;

  for (genvar gk = 0; gk < 2; gk++) begin : g_cnt
    // A clear racing an increment leaves the new revolution counted, not a wrap.
    assign wrap[gk] = sns_rise[gk] & ~cnt_clr[gk] & (&rev_cnt[gk]);

    always_ff @(posedge HCLK) begin
      if (HRESET)            rev_cnt[gk] <= '0;
      else if (cnt_clr[gk])  rev_cnt[gk] <= COUNT_WIDTH'(sns_rise[gk]);
      else if (sns_rise[gk]) rev_cnt[gk] <= rev_cnt[gk] + 1'b1;
    end
  end

  always_comb begin
    ev_set                   = '0;
    ev_set[NUM_BUTTONS-1:0]  = rise[NUM_BUTTONS-1:0];
    ev_set[WHEEL_BIT]        = sns_rise[0];
    ev_set[CRANK_BIT]        = sns_rise[1];
    ev_set[WHEEL_WRAP_BIT]   = wrap[0];
    ev_set[CRANK_WRAP_BIT]   = wrap[1];
  end

  // A set on the same edge as its W1C wins.
  always_ff @(posedge HCLK) begin
    if (HRESET) ev_q <= '0;
    else        ev_q <= (ev_q & ~ev_w1c) | ev_set;
  end

  assign IRQ = |ev_q;

  // ---------------- read mux ----------------
  always_comb begin
    HRDATA = '0;
    if (dp.rd) begin
      case (dp.addr)
        STATUS: begin
          HRDATA[NUM_BUTTONS-1:0] = lvl[NUM_BUTTONS-1:0];
          HRDATA[WHEEL_BIT]       = lvl[WI];
          HRDATA[CRANK_BIT]       = lvl[CI];
        end
        EVENTS:      HRDATA[11:0]            = ev_q;
        WHEEL_COUNT: HRDATA[COUNT_WIDTH-1:0] = rev_cnt[0];
        default:     HRDATA[COUNT_WIDTH-1:0] = rev_cnt[1];
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:12]};

endmodule

// File: tb/tb_ahb_sensor_in.sv
module tb_ahb_sensor_in;

  localparam int NB = 2;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [31:0]   HADDR, HWDATA, HRDATA;
  logic [2:0]    HSIZE;
  logic [1:0]    HTRANS;
  logic          HWRITE, HREADY, HSEL, HREADYOUT, IRQ;
  logic [NB-1:0] nButton;
  logic          nWheel, nCrank;

  ahb_sensor_in #(
    .NUM_BUTTONS(NB), .BTN_DEBOUNCE_CYCLES(4),
    .SNS_DEBOUNCE_CYCLES(4), .COUNT_WIDTH(4)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY),
    .HSEL(HSEL), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .nButton(nButton), .nWheel(nWheel), .nCrank(nCrank), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [1:0]  word;
    logic [31:0] data;
    logic [31:0] exp;
    logic        irq;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(logic wr, logic [1:0] word, logic [31:0] data,
                              logic [31:0] exp, logic irq);
    vec_t v;
    v.wr = wr; v.word = word; v.data = data; v.exp = exp; v.irq = irq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] w, input logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, w, 2'b00};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;  // write has committed
  endtask

  task automatic bus_read(input logic [1:0] w, output logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, w, 2'b00};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic run_table(input int lo, input int hi);
    logic [31:0] rd;
    for (int i = lo; i < hi; i++) begin
      if (tbl[i].wr) begin
        bus_write(tbl[i].word, tbl[i].data);
      end else begin
        bus_read(tbl[i].word, rd);
        check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
      end
      check($sformatf("vec%0d_irq", i), {31'h0, IRQ}, {31'h0, tbl[i].irq});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // IRQ must stay low for 5 edges and rise on the 6th (2 sync + 4 debounce).
  task automatic check_irq_rise(input string name);
    for (int i = 1; i <= 6; i++) begin
      @(posedge HCLK); #1;
      check($sformatf("%s_irq_edge%0d", name, i), {31'h0, IRQ}, {31'h0, (i == 6)});
    end
  endtask

  task automatic pulse_wheel();
    nWheel = 1'b0; idle(8);
    nWheel = 1'b1; idle(8);
  endtask

  task automatic pulse_crank();
    nCrank = 1'b0; idle(8);
    nCrank = 1'b1; idle(8);
  endtask

  initial begin
    logic [31:0] rd;
    int p0, p1, p2, p3, p4;

    // ---- vector tables ----
    p0 = tbl.size();
    tbl.push_back(mk(0, 2'd0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 2'd1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 2'd2, 0, 32'h0, 0));
    tbl.push_back(mk(0, 2'd3, 0, 32'h0, 0));
    p1 = tbl.size();
    tbl.push_back(mk(0, 2'd0, 0, 32'h0, 1));          // button0 released, glitch filtered
    tbl.push_back(mk(0, 2'd1, 0, 32'h1, 1));
    tbl.push_back(mk(1, 2'd1, 32'h0, 32'h0, 1));      // W1C of nothing
    tbl.push_back(mk(0, 2'd1, 0, 32'h1, 1));
    tbl.push_back(mk(1, 2'd1, 32'h1, 32'h0, 0));      // clear bit0 -> IRQ drops
    tbl.push_back(mk(0, 2'd1, 0, 32'h0, 0));
    p2 = tbl.size();
    tbl.push_back(mk(0, 2'd2, 0, 32'h5, 1));
    tbl.push_back(mk(0, 2'd1, 0, 32'h100, 1));
    tbl.push_back(mk(0, 2'd3, 0, 32'h0, 1));
    tbl.push_back(mk(1, 2'd2, 32'h1234, 32'h0, 1));   // clear wheel count
    tbl.push_back(mk(0, 2'd2, 0, 32'h0, 1));
    tbl.push_back(mk(0, 2'd1, 0, 32'h100, 1));        // flag untouched by count clear
    tbl.push_back(mk(1, 2'd1, 32'h100, 32'h0, 0));
    tbl.push_back(mk(0, 2'd1, 0, 32'h0, 0));
    p3 = tbl.size();
    tbl.push_back(mk(0, 2'd3, 0, 32'hF, 1));          // 15 pulses, no wrap yet
    tbl.push_back(mk(0, 2'd1, 0, 32'h200, 1));
    p4 = tbl.size();
    tbl.push_back(mk(0, 2'd3, 0, 32'h0, 1));          // 16th pulse wraps
    tbl.push_back(mk(0, 2'd1, 0, 32'hA00, 1));
    tbl.push_back(mk(1, 2'd1, 32'hFFFF_FFFF, 32'h0, 0));
    tbl.push_back(mk(0, 2'd1, 0, 32'h0, 0));
    tbl.push_back(mk(1, 2'd0, 32'hFFFF_FFFF, 32'h0, 0)); // STATUS is read-only
    tbl.push_back(mk(0, 2'd0, 0, 32'h0, 0));

    // ---- reset ----
    HRESET = 1'b1; HADDR = '0; HWDATA = '0; HSIZE = 3'b010; HTRANS = 2'b00;
    HWRITE = 1'b0; HREADY = 1'b1; HSEL = 1'b0;
    nButton = '1; nWheel = 1'b1; nCrank = 1'b1;
    idle(4);
    check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    HRESET = 1'b0;
    run_table(p0, p1);

    // ---- button0 press: exact latency, then glitch on button1 ----
    @(posedge HCLK); #1;
    nButton[0] = 1'b0;
    check_irq_rise("btn0");
    bus_read(2'd0, rd); check("btn0_status", rd, 32'h1);
    bus_read(2'd1, rd); check("btn0_events", rd, 32'h1);
    nButton[0] = 1'b1;
    idle(2);
    nButton[1] = 1'b0; idle(3);
    nButton[1] = 1'b1; idle(12);
    run_table(p1, p2);

    // ---- wheel revolutions ----
    repeat (5) pulse_wheel();
    idle(4);
    run_table(p2, p3);

    // ---- crank wrap at COUNT_WIDTH=4 ----
    repeat (15) pulse_crank();
    idle(4);
    run_table(p3, p4);
    pulse_crank();
    idle(4);
    run_table(p4, tbl.size());

    // ---- W1C of bit0 committing on the button0 rise edge ----
    @(posedge HCLK); #1;
    nButton[0] = 1'b0;
    repeat (3) @(posedge HCLK);
    bus_write(2'd1, 32'h1);  // commits on edge 6 after the pin fell
    check("race_w1c_irq", {31'h0, IRQ}, 32'h1);
    bus_read(2'd1, rd); check("race_w1c_events", rd, 32'h1);
    nButton[0] = 1'b1; idle(10);
    bus_write(2'd1, 32'hFFF);

    // ---- WHEEL_COUNT clear coinciding with a wheel rise ----
    pulse_wheel();
    idle(4);
    bus_read(2'd2, rd); check("race_clr_pre", rd, 32'h1);
    @(posedge HCLK); #1;
    nWheel = 1'b0;
    repeat (3) @(posedge HCLK);
    bus_write(2'd2, 32'h0);  // commits on the rise edge
    nWheel = 1'b1; idle(10);
    bus_read(2'd2, rd); check("race_clr_count", rd, 32'h1);

    // ---- input held through reset ----
    nButton[1] = 1'b0;
    HRESET = 1'b1; idle(3);
    check("rst2_irq", {31'h0, IRQ}, 32'h0);
    HRESET = 1'b0;
    check_irq_rise("held");
    bus_read(2'd0, rd); check("held_status", rd, 32'h2);
    bus_read(2'd1, rd); check("held_events", rd, 32'h2);
    nButton[1] = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
